// File: rtl/qspi_seq_pkg.sv
// rtl/qspi_seq_pkg.sv - shared codes and helpers for the QSPI phase sequencer
package qspi_seq_pkg;

  typedef enum logic [2:0] {
    SEG_INST  = 3'd0,
    SEG_ADDR  = 3'd1,
    SEG_DUMMY = 3'd2,
    SEG_WDATA = 3'd3,
    SEG_RDATA = 3'd4
  } seg_type_e;

  typedef enum logic [1:0] {
    LANE_SINGLE = 2'd0,
    LANE_DUAL   = 2'd1,
    LANE_QUAD   = 2'd2
  } lane_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INST, ST_ADDR, ST_DUMMY, ST_DATA, ST_WAIT_DONE, ST_POP, ST_GAP
  } state_e;

  // A phase override, when enabled, replaces the global mode; spi wins over dpi.
  function automatic lane_e resolve_lanes(input logic mode_en, input logic spi, input logic dpi,
                                          input logic cur_spi, input logic cur_dpi);
    lane_e lanes;
    logic  s;
    logic  d;
    s = mode_en ? spi : cur_spi;
    d = mode_en ? dpi : cur_dpi;
    if (s)      lanes = LANE_SINGLE;
    else if (d) lanes = LANE_DUAL;
    else        lanes = LANE_QUAD;
    return lanes;
  endfunction

  // Next present phase after cur; ST_WAIT_DONE means nothing is left to issue.
  function automatic state_e phase_after(input state_e cur, input logic addr_p,
                                         input logic dummy_p, input logic data_p);
    state_e nxt;
    nxt = ST_WAIT_DONE;
    if (cur == ST_INST && addr_p)
      nxt = ST_ADDR;
    else if ((cur == ST_INST || cur == ST_ADDR) && dummy_p)
      nxt = ST_DUMMY;
    else if ((cur == ST_INST || cur == ST_ADDR || cur == ST_DUMMY) && data_p)
      nxt = ST_DATA;
    return nxt;
  endfunction

endpackage

// File: rtl/qspi_gap_timer.sv
// rtl/qspi_gap_timer.sv - chip-select gap down-counter
module qspi_gap_timer #(
  parameter int CS_GAP = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expire
);

  logic [3:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= 4'(CS_GAP);
    else if (cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

  // Fires on the final gap cycle so the FSM leaves GAP after exactly CS_GAP cycles.
  assign expire = (cnt == 4'd1);

endmodule

// File: rtl/qspi_phase_seq.sv
// rtl/qspi_phase_seq.sv - issues INST/ADDR/DUMMY/DATA segments for one buffered request
module qspi_phase_seq
  import qspi_seq_pkg::*;
#(
  parameter int CS_GAP = 2,
  parameter int SZ_W   = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_start_signal,
  input  logic            io_addr_valid,
  input  logic            io_dummy_valid,
  input  logic            io_wr_valid,
  input  logic            io_rd_valid,
  input  logic [7:0]      io_inst,
  input  logic [23:0]     io_addr,
  input  logic [SZ_W-1:0] io_inst_size,
  input  logic [SZ_W-1:0] io_inst_burstlen,
  input  logic [SZ_W-1:0] io_addr_size,
  input  logic [SZ_W-1:0] io_addr_burstlen,
  input  logic [SZ_W-1:0] io_dummy_size,
  input  logic [SZ_W-1:0] io_dummy_burstlen,
  input  logic [SZ_W-1:0] io_data_size,
  input  logic [SZ_W-1:0] io_data_burstlen,
  input  logic            io_addr_mode_en,
  input  logic            io_addr_spi_mode,
  input  logic            io_addr_dpi_mode,
  input  logic            io_data_mode_en,
  input  logic            io_data_spi_mode,
  input  logic            io_data_dpi_mode,
  input  logic            io_cur_spi_mode,
  input  logic            io_cur_dpi_mode,
  output logic            io_next_req,
  output logic            io_seg_valid,
  input  logic            io_seg_ready,
  output logic [2:0]      io_seg_type,
  output logic [SZ_W-1:0] io_seg_nibbles,
  output logic [1:0]      io_seg_lanes,
  output logic [23:0]     io_seg_wdata,
  output logic            io_seg_last,
  input  logic            io_seg_done,
  output logic            io_cs_active,
  output logic            io_busy,
  output logic            io_err_pulse
);

  state_e          state;
  logic [SZ_W-1:0] beat_cnt;
  logic            gap_expire;

  logic            r_addr_valid, r_dummy_valid, r_wr, r_rd;
  logic [23:0]     r_addr;
  logic [SZ_W-1:0] r_inst_bl, r_addr_size, r_addr_bl, r_dummy_size, r_dummy_bl, r_data_size, r_data_bl;
  logic            r_addr_mode_en, r_addr_spi, r_addr_dpi, r_data_mode_en, r_data_spi, r_data_dpi;
  logic            r_cur_spi, r_cur_dpi;

  logic            addr_p, dummy_p, data_p, in_addr_p, in_dummy_p, in_data_p;
  logic [SZ_W-1:0] in_inst_bl, cur_bl, beat_inc, tgt_bl, tgt_nib;
  logic            in_inst_last, accept, last_beat, next_beat_last, tgt_last;
  state_e          nxt_phase;
  logic [2:0]      tgt_type;
  logic [1:0]      tgt_lanes;
  logic [23:0]     tgt_wdata;

  qspi_gap_timer #(.CS_GAP(CS_GAP)) u_gap_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (state == ST_POP),
    .expire (gap_expire)
  );

  // The request is copied once; the buffer head is never looked at again until the next IDLE.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && io_start_signal) begin
      r_addr_valid   <= io_addr_valid;
      r_dummy_valid  <= io_dummy_valid;
      r_wr           <= io_wr_valid;
      r_rd           <= io_rd_valid;
      r_addr         <= io_addr;
      r_inst_bl      <= in_inst_bl;
      r_addr_size    <= io_addr_size;
      r_addr_bl      <= io_addr_burstlen;
      r_dummy_size   <= io_dummy_size;
      r_dummy_bl     <= io_dummy_burstlen;
      r_data_size    <= io_data_size;
      r_data_bl      <= io_data_burstlen;
      r_addr_mode_en <= io_addr_mode_en;
      r_addr_spi     <= io_addr_spi_mode;
      r_addr_dpi     <= io_addr_dpi_mode;
      r_data_mode_en <= io_data_mode_en;
      r_data_spi     <= io_data_spi_mode;
      r_data_dpi     <= io_data_dpi_mode;
      r_cur_spi      <= io_cur_spi_mode;
      r_cur_dpi      <= io_cur_dpi_mode;
    end
  end

  always_comb begin
    in_addr_p    = io_addr_valid && (io_addr_burstlen != '0);
    in_dummy_p   = io_dummy_valid && (io_dummy_burstlen != '0);
    in_data_p    = (io_wr_valid || io_rd_valid) && (io_data_burstlen != '0);
    in_inst_bl   = (io_inst_burstlen == '0) ? SZ_W'(1) : io_inst_burstlen;
    in_inst_last = (in_inst_bl == SZ_W'(1)) &&
                   (phase_after(ST_INST, in_addr_p, in_dummy_p, in_data_p) == ST_WAIT_DONE);

    addr_p  = r_addr_valid && (r_addr_bl != '0);
    dummy_p = r_dummy_valid && (r_dummy_bl != '0);
    data_p  = (r_wr || r_rd) && (r_data_bl != '0);

    case (state)
      ST_INST:  cur_bl = r_inst_bl;
      ST_ADDR:  cur_bl = r_addr_bl;
      ST_DUMMY: cur_bl = r_dummy_bl;
      ST_DATA:  cur_bl = r_data_bl;
      default:  cur_bl = SZ_W'(1);
    endcase
    accept         = io_seg_valid && io_seg_ready;
    beat_inc       = beat_cnt + SZ_W'(1);
    last_beat      = (beat_inc == cur_bl);
    nxt_phase      = phase_after(state, addr_p, dummy_p, data_p);
    next_beat_last = (beat_inc + SZ_W'(1) == cur_bl) && (nxt_phase == ST_WAIT_DONE);

    tgt_type  = 3'd0;
    tgt_nib   = '0;
    tgt_lanes = 2'd0;
    tgt_wdata = 24'd0;
    tgt_bl    = '0;
    case (nxt_phase)
      ST_ADDR: begin
        tgt_type  = SEG_ADDR;
        tgt_nib   = r_addr_size;
        tgt_lanes = resolve_lanes(r_addr_mode_en, r_addr_spi, r_addr_dpi, r_cur_spi, r_cur_dpi);
        tgt_wdata = r_addr;
        tgt_bl    = r_addr_bl;
      end
      ST_DUMMY: begin
        tgt_type  = SEG_DUMMY;
        tgt_nib   = r_dummy_size;
        tgt_lanes = resolve_lanes(1'b0, 1'b0, 1'b0, r_cur_spi, r_cur_dpi);
        tgt_bl    = r_dummy_bl;
      end
      ST_DATA: begin
        tgt_type  = r_wr ? SEG_WDATA : SEG_RDATA;
        tgt_nib   = r_data_size;
        tgt_lanes = resolve_lanes(r_data_mode_en, r_data_spi, r_data_dpi, r_cur_spi, r_cur_dpi);
        tgt_bl    = r_data_bl;
      end
      default: ;
    endcase
    tgt_last = (tgt_bl == SZ_W'(1)) &&
               (phase_after(nxt_phase, addr_p, dummy_p, data_p) == ST_WAIT_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      beat_cnt       <= '0;
      io_next_req    <= 1'b0;
      io_seg_valid   <= 1'b0;
      io_seg_type    <= 3'd0;
      io_seg_nibbles <= '0;
      io_seg_lanes   <= 2'd0;
      io_seg_wdata   <= 24'd0;
      io_seg_last    <= 1'b0;
      io_cs_active   <= 1'b0;
      io_busy        <= 1'b0;
      io_err_pulse   <= 1'b0;
    end else begin
      io_next_req  <= 1'b0;
      io_err_pulse <= 1'b0;
      case (state)
        ST_IDLE: if (io_start_signal) begin
          state          <= ST_INST;
          beat_cnt       <= '0;
          io_seg_valid   <= 1'b1;
          io_seg_type    <= SEG_INST;
          io_seg_nibbles <= io_inst_size;
          io_seg_lanes   <= resolve_lanes(1'b0, 1'b0, 1'b0, io_cur_spi_mode, io_cur_dpi_mode);
          io_seg_wdata   <= {io_inst, 16'h0000};
          io_seg_last    <= in_inst_last;
          io_cs_active   <= 1'b1;
          io_busy        <= 1'b1;
          io_err_pulse   <= io_wr_valid && io_rd_valid;
        end
        ST_INST, ST_ADDR, ST_DUMMY, ST_DATA: if (accept) begin
          if (!last_beat) begin
            beat_cnt    <= beat_inc;
            io_seg_last <= next_beat_last;
          end else begin
            beat_cnt       <= '0;
            io_seg_type    <= tgt_type;
            io_seg_nibbles <= tgt_nib;
            io_seg_lanes   <= tgt_lanes;
            io_seg_wdata   <= tgt_wdata;
            io_seg_last    <= tgt_last;
            if (nxt_phase != ST_WAIT_DONE) begin
              state <= nxt_phase;
            end else begin
              io_seg_valid <= 1'b0;
              state        <= io_seg_done ? ST_POP : ST_WAIT_DONE;
              io_next_req  <= io_seg_done;
            end
          end
        end
        ST_WAIT_DONE: if (io_seg_done) begin
          state       <= ST_POP;
          io_next_req <= 1'b1;
        end
        ST_POP: begin
          state        <= ST_GAP;
          io_cs_active <= 1'b0;
        end
        ST_GAP: if (gap_expire) begin
          state   <= ST_IDLE;
          io_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_phase_seq.sv
// tb/tb_qspi_phase_seq.sv - directed self-checking bench for qspi_phase_seq
module tb_qspi_phase_seq;

  typedef struct packed {
    logic [2:0]  t;
    logic [7:0]  n;
    logic [1:0]  l;
    logic [23:0] w;
    logic        last;
  } seg_s;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_start_signal, io_addr_valid, io_dummy_valid, io_wr_valid, io_rd_valid;
  logic [7:0]  io_inst;
  logic [23:0] io_addr;
  logic [7:0]  io_inst_size, io_inst_burstlen, io_addr_size, io_addr_burstlen;
  logic [7:0]  io_dummy_size, io_dummy_burstlen, io_data_size, io_data_burstlen;
  logic        io_addr_mode_en, io_addr_spi_mode, io_addr_dpi_mode;
  logic        io_data_mode_en, io_data_spi_mode, io_data_dpi_mode;
  logic        io_cur_spi_mode, io_cur_dpi_mode;
  logic        io_next_req, io_seg_valid, io_seg_ready, io_seg_last, io_seg_done;
  logic [2:0]  io_seg_type;
  logic [7:0]  io_seg_nibbles;
  logic [1:0]  io_seg_lanes;
  logic [23:0] io_seg_wdata;
  logic        io_cs_active, io_busy, io_err_pulse;

  int   checks = 0;
  int   failures = 0;
  seg_s segs[$];
  int   nreq, gap_cyc, err_cyc, last_cyc, req_cyc, stall_cnt, stall_bad;

  qspi_phase_seq #(.CS_GAP(2), .SZ_W(8)) dut (
    .clock(clock), .reset(reset), .io_start_signal(io_start_signal),
    .io_addr_valid(io_addr_valid), .io_dummy_valid(io_dummy_valid),
    .io_wr_valid(io_wr_valid), .io_rd_valid(io_rd_valid),
    .io_inst(io_inst), .io_addr(io_addr),
    .io_inst_size(io_inst_size), .io_inst_burstlen(io_inst_burstlen),
    .io_addr_size(io_addr_size), .io_addr_burstlen(io_addr_burstlen),
    .io_dummy_size(io_dummy_size), .io_dummy_burstlen(io_dummy_burstlen),
    .io_data_size(io_data_size), .io_data_burstlen(io_data_burstlen),
    .io_addr_mode_en(io_addr_mode_en), .io_addr_spi_mode(io_addr_spi_mode),
    .io_addr_dpi_mode(io_addr_dpi_mode), .io_data_mode_en(io_data_mode_en),
    .io_data_spi_mode(io_data_spi_mode), .io_data_dpi_mode(io_data_dpi_mode),
    .io_cur_spi_mode(io_cur_spi_mode), .io_cur_dpi_mode(io_cur_dpi_mode),
    .io_next_req(io_next_req), .io_seg_valid(io_seg_valid), .io_seg_ready(io_seg_ready),
    .io_seg_type(io_seg_type), .io_seg_nibbles(io_seg_nibbles), .io_seg_lanes(io_seg_lanes),
    .io_seg_wdata(io_seg_wdata), .io_seg_last(io_seg_last), .io_seg_done(io_seg_done),
    .io_cs_active(io_cs_active), .io_busy(io_busy), .io_err_pulse(io_err_pulse)
  );

  always #5 clock = ~clock;

  function automatic seg_s mk(input logic [2:0] t, input logic [7:0] n, input logic [1:0] l,
                              input logic [23:0] w, input logic last);
    return {t, n, l, w, last};
  endfunction

  task automatic clear_req();
    io_start_signal = 0; io_addr_valid = 0; io_dummy_valid = 0; io_wr_valid = 0; io_rd_valid = 0;
    io_inst = 0; io_addr = 0;
    io_inst_size = 0; io_inst_burstlen = 0; io_addr_size = 0; io_addr_burstlen = 0;
    io_dummy_size = 0; io_dummy_burstlen = 0; io_data_size = 0; io_data_burstlen = 0;
    io_addr_mode_en = 0; io_addr_spi_mode = 0; io_addr_dpi_mode = 0;
    io_data_mode_en = 0; io_data_spi_mode = 0; io_data_dpi_mode = 0;
    io_cur_spi_mode = 0; io_cur_dpi_mode = 0;
  endtask

  // Plays the shifter: records accepted segments, optionally stalls one segment type,
  // raises seg_done done_delay cycles after the last accept.
  task automatic run_txn(input int done_delay, input int stall_type, output bit to);
    int   wait_done;
    int   stall_left;
    seg_s cur;
    seg_s held;
    segs.delete();
    nreq = 0; gap_cyc = 0; err_cyc = 0; last_cyc = -1; req_cyc = -1;
    stall_cnt = 0; stall_bad = 0; wait_done = -1; held = '0;
    stall_left = (stall_type >= 0) ? 5 : 0;
    to = 1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clock); #1;
      io_seg_done = 0;
      if (io_busy) io_start_signal = 0;
      if (io_next_req) begin nreq++; req_cyc = c; end
      if (io_err_pulse) err_cyc++;
      if (io_busy && !io_cs_active) gap_cyc++;
      if (nreq > 0 && !io_busy) begin to = 0; break; end
      if (wait_done > 0) begin
        wait_done--;
        if (wait_done == 0) begin io_seg_done = 1; wait_done = -1; end
      end
      cur = {io_seg_type, io_seg_nibbles, io_seg_lanes, io_seg_wdata, io_seg_last};
      if (io_seg_valid && int'(io_seg_type) == stall_type && stall_left > 0) begin
        io_seg_ready = 0;
        if (stall_cnt == 0) held = cur;
        else if (cur !== held) stall_bad++;
        stall_cnt++;
        stall_left--;
      end else begin
        io_seg_ready = 1;
        if (io_seg_valid) begin
          segs.push_back(cur);
          if (io_seg_last) begin
            last_cyc = c;
            if (done_delay == 0) io_seg_done = 1;
            else wait_done = done_delay;
          end
        end
      end
    end
    io_seg_ready = 1;
    io_seg_done = 0;
  endtask

  task automatic setup_read();
    clear_req();
    io_inst = 8'h03; io_addr = 24'h123456; io_addr_valid = 1; io_rd_valid = 1;
    io_inst_size = 2; io_inst_burstlen = 1; io_addr_size = 6; io_addr_burstlen = 1;
    io_data_size = 2; io_data_burstlen = 4; io_cur_spi_mode = 1;
  endtask

  task automatic test_reset();
    logic [42:0] outs;
    reset = 1; clear_req(); io_seg_ready = 1; io_seg_done = 0;
    repeat (3) @(posedge clock);
    #1;
    outs = {io_next_req, io_seg_valid, io_seg_type, io_seg_nibbles, io_seg_lanes,
            io_seg_wdata, io_seg_last, io_cs_active, io_busy, io_err_pulse};
    checks++;
    if (outs !== 43'd0) begin failures++; $display("FAIL reset_outputs got %h exp 0", outs); end
    io_start_signal = 1;
    @(posedge clock); #1;
    checks++;
    if (io_busy !== 1'b0) begin failures++; $display("FAIL reset_blocks_start busy got %b exp 0", io_busy); end
    io_start_signal = 0; reset = 0;
    @(posedge clock); #1;
    checks++;
    if (io_busy !== 1'b0 || io_cs_active !== 1'b0) begin
      failures++; $display("FAIL idle_no_start busy/cs got %b%b exp 00", io_busy, io_cs_active);
    end
  endtask

  task automatic test_read();
    seg_s exp[$];
    bit   to;
    setup_read();
    io_start_signal = 1;
    run_txn(3, -1, to);
    exp.push_back(mk(0, 2, 0, 24'h030000, 0));
    exp.push_back(mk(1, 6, 0, 24'h123456, 0));
    for (int i = 0; i < 4; i++) exp.push_back(mk(4, 2, 0, 24'h0, i == 3));
    checks++; if (to) begin failures++; $display("FAIL read_timeout got 1 exp 0"); end
    checks++;
    if (segs.size() != exp.size()) begin failures++; $display("FAIL read_count got %0d exp %0d", segs.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < segs.size(); i++) begin
      checks++;
      if (segs[i] !== exp[i]) begin failures++; $display("FAIL read_seg%0d got %h exp %h", i, segs[i], exp[i]); end
    end
    checks++; if (nreq != 1) begin failures++; $display("FAIL read_next_req got %0d exp 1", nreq); end
    checks++;
    if (req_cyc - last_cyc != 4) begin failures++; $display("FAIL read_pop_after_done got %0d exp 4", req_cyc - last_cyc); end
    checks++; if (gap_cyc != 2) begin failures++; $display("FAIL read_cs_gap got %0d exp 2", gap_cyc); end
    checks++; if (err_cyc != 0) begin failures++; $display("FAIL read_err got %0d exp 0", err_cyc); end
  endtask

  task automatic test_wren();
    bit to;
    clear_req();
    io_inst = 8'h06; io_inst_size = 2; io_inst_burstlen = 0; io_cur_spi_mode = 1;
    io_start_signal = 1;
    run_txn(0, -1, to);
    checks++; if (to) begin failures++; $display("FAIL wren_timeout got 1 exp 0"); end
    checks++;
    if (segs.size() != 1) begin failures++; $display("FAIL wren_count got %0d exp 1", segs.size()); end
    else begin
      checks++;
      if (segs[0] !== mk(0, 2, 0, 24'h060000, 1)) begin
        failures++; $display("FAIL wren_seg got %h exp %h", segs[0], mk(0, 2, 0, 24'h060000, 1));
      end
    end
    checks++;
    if (nreq != 1 || req_cyc - last_cyc != 1) begin
      failures++; $display("FAIL wren_pop got n=%0d d=%0d exp n=1 d=1", nreq, req_cyc - last_cyc);
    end
    checks++; if (gap_cyc != 2) begin failures++; $display("FAIL wren_gap got %0d exp 2", gap_cyc); end
  endtask

  task automatic test_fast_read();
    seg_s exp[$];
    bit   to;
    clear_req();
    io_inst = 8'h0B; io_addr = 24'h000100; io_addr_valid = 1; io_dummy_valid = 1; io_rd_valid = 1;
    io_inst_size = 2; io_inst_burstlen = 1; io_addr_size = 6; io_addr_burstlen = 1;
    io_dummy_size = 8; io_dummy_burstlen = 1; io_data_size = 2; io_data_burstlen = 2;
    io_data_mode_en = 1; io_cur_spi_mode = 1;
    io_start_signal = 1;
    run_txn(1, -1, to);
    exp.push_back(mk(0, 2, 0, 24'h0B0000, 0));
    exp.push_back(mk(1, 6, 0, 24'h000100, 0));
    exp.push_back(mk(2, 8, 0, 24'h0, 0));
    exp.push_back(mk(4, 2, 2, 24'h0, 0));
    exp.push_back(mk(4, 2, 2, 24'h0, 1));
    checks++; if (to) begin failures++; $display("FAIL fast_timeout got 1 exp 0"); end
    checks++;
    if (segs.size() != exp.size()) begin failures++; $display("FAIL fast_count got %0d exp %0d", segs.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < segs.size(); i++) begin
      checks++;
      if (segs[i] !== exp[i]) begin failures++; $display("FAIL fast_seg%0d got %h exp %h", i, segs[i], exp[i]); end
    end
  endtask

  task automatic test_stall();
    seg_s exp[$];
    bit   to;
    setup_read();
    io_start_signal = 1;
    run_txn(2, 1, to);
    exp.push_back(mk(0, 2, 0, 24'h030000, 0));
    exp.push_back(mk(1, 6, 0, 24'h123456, 0));
    for (int i = 0; i < 4; i++) exp.push_back(mk(4, 2, 0, 24'h0, i == 3));
    checks++; if (to) begin failures++; $display("FAIL stall_timeout got 1 exp 0"); end
    checks++; if (stall_cnt != 5) begin failures++; $display("FAIL stall_valid_held got %0d exp 5", stall_cnt); end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_fields_stable got %0d exp 0", stall_bad); end
    checks++;
    if (segs.size() != exp.size()) begin failures++; $display("FAIL stall_count got %0d exp %0d", segs.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < segs.size(); i++) begin
      checks++;
      if (segs[i] !== exp[i]) begin failures++; $display("FAIL stall_seg%0d got %h exp %h", i, segs[i], exp[i]); end
    end
  endtask

  task automatic test_err();
    seg_s exp[$];
    bit   to;
    clear_req();
    io_inst = 8'h02; io_addr = 24'hABCDEF; io_addr_valid = 1; io_wr_valid = 1; io_rd_valid = 1;
    io_inst_size = 2; io_inst_burstlen = 1; io_addr_size = 6; io_addr_burstlen = 1;
    io_data_size = 2; io_data_burstlen = 2;
    io_data_mode_en = 1; io_data_spi_mode = 1; io_data_dpi_mode = 1; io_cur_dpi_mode = 1;
    io_start_signal = 1;
    run_txn(1, -1, to);
    exp.push_back(mk(0, 2, 1, 24'h020000, 0));
    exp.push_back(mk(1, 6, 1, 24'hABCDEF, 0));
    exp.push_back(mk(3, 2, 0, 24'h0, 0));
    exp.push_back(mk(3, 2, 0, 24'h0, 1));
    checks++; if (to) begin failures++; $display("FAIL err_timeout got 1 exp 0"); end
    checks++; if (err_cyc != 1) begin failures++; $display("FAIL err_pulse_cycles got %0d exp 1", err_cyc); end
    checks++;
    if (segs.size() != exp.size()) begin failures++; $display("FAIL err_count got %0d exp %0d", segs.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < segs.size(); i++) begin
      checks++;
      if (segs[i] !== exp[i]) begin failures++; $display("FAIL err_seg%0d got %h exp %h", i, segs[i], exp[i]); end
    end
  endtask

  task automatic test_dummy_skip();
    seg_s exp[$];
    bit   to;
    clear_req();
    io_inst = 8'h0B; io_addr = 24'h00FF00; io_addr_valid = 1; io_dummy_valid = 1; io_rd_valid = 1;
    io_inst_size = 2; io_inst_burstlen = 1; io_addr_size = 6; io_addr_burstlen = 1;
    io_dummy_size = 8; io_dummy_burstlen = 0; io_data_size = 2; io_data_burstlen = 1;
    io_start_signal = 1;
    run_txn(0, -1, to);
    exp.push_back(mk(0, 2, 2, 24'h0B0000, 0));
    exp.push_back(mk(1, 6, 2, 24'h00FF00, 0));
    exp.push_back(mk(4, 2, 2, 24'h0, 1));
    checks++; if (to) begin failures++; $display("FAIL skip_timeout got 1 exp 0"); end
    checks++;
    if (segs.size() != exp.size()) begin failures++; $display("FAIL skip_count got %0d exp %0d", segs.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < segs.size(); i++) begin
      checks++;
      if (segs[i] !== exp[i]) begin failures++; $display("FAIL skip_seg%0d got %h exp %h", i, segs[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [42:0] outs;
    int          rdata_seen;
    int          aborted_req;
    bit          hit;
    bit          to;
    setup_read();
    io_start_signal = 1; io_seg_ready = 1;
    rdata_seen = 0; aborted_req = 0; hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clock); #1;
      if (io_next_req) aborted_req++;
      if (io_seg_valid && io_seg_type == 3'd4) begin
        if (rdata_seen == 1) begin reset = 1; hit = 1; break; end
        rdata_seen++;
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rst_reach_beat2 got 0 exp 1"); end
    @(posedge clock); #1;
    outs = {io_next_req, io_seg_valid, io_seg_type, io_seg_nibbles, io_seg_lanes,
            io_seg_wdata, io_seg_last, io_cs_active, io_busy, io_err_pulse};
    checks++;
    if (outs !== 43'd0) begin failures++; $display("FAIL rst_mid_outputs got %h exp 0", outs); end
    checks++; if (aborted_req != 0) begin failures++; $display("FAIL rst_mid_next_req got %0d exp 0", aborted_req); end
    reset = 0;
    run_txn(1, -1, to);
    checks++; if (to) begin failures++; $display("FAIL replay_timeout got 1 exp 0"); end
    checks++; if (segs.size() != 6) begin failures++; $display("FAIL replay_count got %0d exp 6", segs.size()); end
    else begin
      checks++;
      if (segs[0] !== mk(0, 2, 0, 24'h030000, 0)) begin failures++; $display("FAIL replay_inst got %h", segs[0]); end
      checks++;
      if (segs[5] !== mk(4, 2, 0, 24'h0, 1)) begin failures++; $display("FAIL replay_last got %h", segs[5]); end
    end
    checks++; if (nreq != 1) begin failures++; $display("FAIL replay_next_req got %0d exp 1", nreq); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_wren();
    test_fast_read();
    test_stall();
    test_err();
    test_dummy_skip();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
